axi_read_arbiter: RTL

Shares the single downstream AXI read channel (AR + R) between the instruction cache refill path and the data cache miss handler. Each accepted read address goes through a one-entry output register. Read data beats are routed back to their requester by a source tag in the top ID bit. A per-source outstanding counter bounds in-flight bursts. The block sits between the ICache/DCache-miss AXI masters and the memory-side AXI crossbar.

---
 rtl/axi_read_arbiter_pkg.sv | 27 ++
 rtl/axi_read_arbiter_sva.sv | 13 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/axi_read_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/axi_read_arbiter_pkg.sv
// Shared types for the ICache/DCache read-channel arbiter: source index,
// AR slot state and the latched AR payload.
package axi_read_arbiter_pkg;

    localparam int AR_ID_WIDTH   = 4;
    localparam int AR_ADDR_WIDTH = 32;

    typedef enum logic {
        AR_SRC_ICACHE = 1'b0,
        AR_SRC_DCACHE = 1'b1
    } ar_src_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Downstream id carries the source tag in its MSB.
    typedef struct packed {
        logic [AR_ADDR_WIDTH-1:0] addr;
        logic [AR_ID_WIDTH:0]     id;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } ArSlot;

endpackage

// File: rtl/axi_read_arbiter_sva.sv
// Protocol checks for the read arbiter: no burst completion may arrive for a
// source that has nothing outstanding.
module axi_read_arbiter_sva (
    input logic       clk,
    input logic       rst,
    input logic [1:0] dec,
    input logic [1:0] cnt_zero
);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        (dec & cnt_zero) == 2'b00);

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant when enabled, priority flips
// away from whichever source was just served.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic prio_r;

    // Grant selection: the favoured source wins a tie, a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        if (!grant_en) begin
            grant = 2'b00;
        end else if (eligible == 2'b11) begin
            grant = prio_r ? 2'b10 : 2'b01;
        end else begin
            grant = eligible;
        end
    end

    // Priority register: favour the source that was not just granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_r <= 1'b0;
        end else if (grant[0]) begin
            prio_r <= 1'b1;
        end else if (grant[1]) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one downstream AXI read channel between ICache refill and DCache miss
// masters: registered AR slot, tagged R return routing, per-source burst limits.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int ID_WIDTH        = AR_ID_WIDTH,
    parameter int ADDR_WIDTH      = AR_ADDR_WIDTH,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    s_arvalid,
    output logic [1:0]                    s_arready,
    input  logic [1:0][ADDR_WIDTH-1:0]    s_araddr,
    input  logic [1:0][ID_WIDTH-1:0]      s_arid,
    input  logic [1:0][7:0]               s_arlen,
    input  logic [1:0][2:0]               s_arsize,
    input  logic [1:0][1:0]               s_arburst,
    output logic [1:0]                    s_rvalid,
    input  logic [1:0]                    s_rready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [ID_WIDTH-1:0]           s_rid,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [ID_WIDTH:0]             m_arid,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [ID_WIDTH:0]             m_rid,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    slot_state_e            state_r;
    slot_state_e            state_next_s;
    ArSlot                  slot_r;
    ArSlot                  slot_next_s;
    logic [1:0][CNT_W-1:0]  cnt_r;
    logic [1:0]             eligible_s;
    logic [1:0]             grant_s;
    logic [1:0]             dec_s;
    logic [1:0]             cnt_zero_s;
    logic                   accept_s;
    logic                   grant_en_s;
    logic                   gnt_idx_s;
    ar_src_e                gnt_src_s;
    ar_src_e                r_src_s;

    assign accept_s   = (state_r == SLOT_FULL) & m_arready;
    assign grant_en_s = (state_r == SLOT_EMPTY) | accept_s;
    assign cnt_zero_s = {cnt_r[1] == '0, cnt_r[0] == '0};
    // A source at its limit stays ineligible even if its last rlast lands this cycle.
    assign eligible_s = {s_arvalid[1] & (cnt_r[1] != CNT_MAX),
                         s_arvalid[0] & (cnt_r[0] != CNT_MAX)};

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible_s),
        .grant_en (grant_en_s),
        .grant    (grant_s)
    );

    assign s_arready = grant_s;
    assign gnt_idx_s = grant_s[1];
    assign gnt_src_s = gnt_idx_s ? AR_SRC_DCACHE : AR_SRC_ICACHE;

    // Slot next-state and payload selection for the granted source.
    always_comb begin
        state_next_s      = state_r;
        slot_next_s       = slot_r;
        slot_next_s.addr  = s_araddr[gnt_idx_s];
        slot_next_s.id    = {gnt_src_s, s_arid[gnt_idx_s]};
        slot_next_s.len   = s_arlen[gnt_idx_s];
        slot_next_s.size  = s_arsize[gnt_idx_s];
        slot_next_s.burst = s_arburst[gnt_idx_s];
        case (state_r)
            SLOT_EMPTY: begin
                if (|grant_s) state_next_s = SLOT_FULL;
                else          state_next_s = SLOT_EMPTY;
            end
            SLOT_FULL: begin
                if (accept_s && !(|grant_s)) state_next_s = SLOT_EMPTY;
                else                         state_next_s = SLOT_FULL;
            end
            default: state_next_s = SLOT_EMPTY;
        endcase
    end

    // Slot state and payload registers; payload only moves on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= SLOT_EMPTY;
            slot_r  <= '0;
        end else if (|grant_s) begin
            state_r <= state_next_s;
            slot_r  <= slot_next_s;
        end else begin
            state_r <= state_next_s;
            slot_r  <= slot_r;
        end
    end

    assign m_arvalid = (state_r == SLOT_FULL);
    assign m_araddr  = slot_r.addr;
    assign m_arid    = slot_r.id;
    assign m_arlen   = slot_r.len;
    assign m_arsize  = slot_r.size;
    assign m_arburst = slot_r.burst;

    assign r_src_s  = ar_src_e'(m_rid[ID_WIDTH]);
    assign s_rvalid = (r_src_s == AR_SRC_DCACHE) ? {m_rvalid, 1'b0} : {1'b0, m_rvalid};
    assign m_rready = (r_src_s == AR_SRC_DCACHE) ? s_rready[1] : s_rready[0];
    assign s_rdata  = m_rdata;
    assign s_rid    = m_rid[ID_WIDTH-1:0];
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;
    assign dec_s    = s_rvalid & {2{m_rready & m_rlast}};

    // Outstanding-burst counters; a same-cycle grant and completion cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant_s[i] && !dec_s[i]) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end else if (dec_s[i] && !grant_s[i] && !cnt_zero_s[i]) begin
                    cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    axi_read_arbiter_sva u_sva (
        .clk      (clk),
        .rst      (rst),
        .dec      (dec_s),
        .cnt_zero (cnt_zero_s)
    );

endmodule
